mcp4921_dac_writer: RTL and testbench

Streaming write controller for the MCP4921 12-bit SPI DAC. It accepts 12-bit unsigned audio samples over a valid/ready handshake and buffers one sample while a frame is in flight. Each sample becomes a 16-bit MCP4921 write frame, and the block generates chip-select, serial clock and data itself. It sits directly downstream of the sample source (DDS/filter offset-binary output) and drives the board's mcp_ss/mcp_clk/mcp_mosi pins. It replaces the free-running divider and chip-select counters plus the generic SPI master on that path.

---
 rtl/mcp4921_dac_writer.sv | 188 ++++++++++++++++++
 tb/tb_mcp4921_dac_writer.sv | 464 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcp4921_dac_writer.sv
// mcp4921_dac_writer
//
// Streaming write controller for the MCP4921 12-bit SPI DAC (SPI mode 0).
// Each accepted 12-bit sample becomes the frame {1'b0, CFG_BITS, sample}.
// The frame is shifted out MSB first on mcp_mosi while the block drives
// mcp_ss and mcp_clk itself. One sample can wait in a holding register while
// the previous frame is still in flight.
//
// Handshake: a sample transfers on a rising clk edge where sample_valid and
// sample_ready are both high. sample_ready is high exactly when the holding
// register is empty. While it is low the source must hold its sample, and
// sample_valid is ignored.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset; aborts any frame in flight
//   sample_valid sample_data is valid
//   sample_data  12-bit unsigned DAC code
//   sample_ready holding register is empty
//   busy         a frame is in progress (FSM not idle)
//   frame_done   one-cycle pulse on the cycle mcp_ss rises at frame end
//   mcp_ss       DAC chip select, active-low
//   mcp_clk      DAC serial clock, idles low
//   mcp_mosi     DAC serial data, MSB first
//
// All outputs come straight from flops. Each output flop is loaded from the
// next-state value, so an output changes on the same edge as the state that
// produces it.
module mcp4921_dac_writer #(
    parameter int          CLK_DIV  = 25,
    parameter int          CS_SETUP = 2,
    parameter int          CS_HOLD  = 2,
    parameter int          CS_GAP   = 4,
    parameter logic [2:0]  CFG_BITS = 3'b011
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sample_valid,
    input  logic [11:0] sample_data,
    output logic        sample_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        mcp_ss,
    output logic        mcp_clk,
    output logic        mcp_mosi
);

    localparam int DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TMAX = (CS_SETUP > CS_HOLD) ?
                          ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                          ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        SHIFT = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state, state_n;
    logic          hold_full, hold_full_n;
    logic [11:0]   hold_data, hold_data_n;
    logic [15:0]   shreg, shreg_n;
    logic [DW-1:0] div_cnt, div_n;
    logic [TW-1:0] tmr, tmr_n;
    logic [3:0]    bit_cnt, bit_n;
    logic          phase, phase_n;     // 0 = sclk low half, 1 = sclk high half
    logic          active_n;

    always_comb begin
        state_n     = state;
        hold_full_n = hold_full;
        hold_data_n = hold_data;
        shreg_n     = shreg;
        div_n       = div_cnt;
        tmr_n       = tmr;
        bit_n       = bit_cnt;
        phase_n     = phase;

        // Capture is independent of the FSM, so the next sample is buffered
        // while the current frame is shifting.
        if (sample_valid && !hold_full) begin
            hold_full_n = 1'b1;
            hold_data_n = sample_data;
        end

        case (state)
            IDLE: begin
                if (hold_full) begin
                    shreg_n     = {1'b0, CFG_BITS, hold_data};
                    hold_full_n = 1'b0;
                    tmr_n       = '0;
                    state_n     = SETUP;
                end
            end
            SETUP: begin
                if (tmr == TW'(CS_SETUP - 1)) begin
                    tmr_n   = '0;
                    div_n   = '0;
                    phase_n = 1'b0;
                    bit_n   = 4'd0;
                    state_n = SHIFT;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            SHIFT: begin
                if (div_cnt == DW'(CLK_DIV - 1)) begin
                    div_n = '0;
                    if (!phase) begin
                        phase_n = 1'b1;
                    end else begin
                        // End of a high half: the next data bit appears at the
                        // start of the following low half, well before the
                        // rising edge where the DAC latches it.
                        phase_n = 1'b0;
                        if (bit_cnt == 4'd15) begin
                            bit_n   = 4'd0;
                            tmr_n   = '0;
                            state_n = HOLD;
                        end else begin
                            bit_n   = bit_cnt + 4'd1;
                            shreg_n = {shreg[14:0], 1'b0};
                        end
                    end
                end else begin
                    div_n = div_cnt + DW'(1);
                end
            end
            HOLD: begin
                if (tmr == TW'(CS_HOLD - 1)) begin
                    tmr_n   = '0;
                    state_n = GAP;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            GAP: begin
                if (tmr == TW'(CS_GAP - 1)) begin
                    tmr_n   = '0;
                    state_n = IDLE;
                end else begin
                    tmr_n = tmr + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        active_n = (state_n == SETUP) || (state_n == SHIFT) || (state_n == HOLD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            hold_full    <= 1'b0;
            hold_data    <= 12'd0;
            shreg        <= 16'd0;
            div_cnt      <= '0;
            tmr          <= '0;
            bit_cnt      <= 4'd0;
            phase        <= 1'b0;
            sample_ready <= 1'b1;
            busy         <= 1'b0;
            frame_done   <= 1'b0;
            mcp_ss       <= 1'b1;
            mcp_clk      <= 1'b0;
            mcp_mosi     <= 1'b0;
        end else begin
            state        <= state_n;
            hold_full    <= hold_full_n;
            hold_data    <= hold_data_n;
            shreg        <= shreg_n;
            div_cnt      <= div_n;
            tmr          <= tmr_n;
            bit_cnt      <= bit_n;
            phase        <= phase_n;
            sample_ready <= !hold_full_n;
            busy         <= (state_n != IDLE);
            frame_done   <= (state_n == GAP) && (state != GAP);
            mcp_ss       <= !active_n;
            mcp_clk      <= (state_n == SHIFT) && phase_n;
            mcp_mosi     <= active_n && shreg_n[15];
        end
    end

endmodule

// File: tb/tb_mcp4921_dac_writer.sv
// Testbench for mcp4921_dac_writer: a default-parameter instance decoded by a
// pin monitor, and a fast-parameter instance checked by an inline sampler.
module tb_mcp4921_dac_writer;

  localparam int CD = 25;
  localparam int SS_LOW = 2 + 32 * CD + 2;     // 804
  localparam int PERIOD = SS_LOW + 4 + 1;      // 809

  typedef struct {
    logic [15:0] word;
    int          low_len;
    int          rises;
    int          bad_half;
    logic        fd_ok;
    longint      fall_t;
  } frame_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic        s_valid, s_ready, busy, fdone, ss, sck, mosi;
  logic [11:0] s_data;
  // fast instance
  logic        v2, r2, b2, fd2, ss2, sck2, mosi2;
  logic [11:0] d2;

  mcp4921_dac_writer dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(s_valid), .sample_data(s_data),
    .sample_ready(s_ready), .busy(busy), .frame_done(fdone),
    .mcp_ss(ss), .mcp_clk(sck), .mcp_mosi(mosi)
  );

  mcp4921_dac_writer #(
    .CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1), .CFG_BITS(3'b111)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .sample_valid(v2), .sample_data(d2),
    .sample_ready(r2), .busy(b2), .frame_done(fd2),
    .mcp_ss(ss2), .mcp_clk(sck2), .mcp_mosi(mosi2)
  );

  int total = 0;
  int bad = 0;
  longint cyc = 0;
  int fd_total = 0;
  logic [15:0] exp_q[$];
  frame_t obs_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Pin monitor for the default instance, sampled on the falling edge.
  logic        m_pss = 1'b1;
  logic        m_pclk = 1'b0;
  int          m_len, m_rises, m_bad, m_run;
  logic [15:0] m_word;
  longint      m_fall;

  initial begin
    m_len = 0; m_rises = 0; m_bad = 0; m_run = 0; m_word = 16'd0; m_fall = 0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        m_pss = 1'b1; m_pclk = 1'b0; m_len = 0; m_rises = 0; m_bad = 0; m_run = 0;
      end else begin
        if (fdone === 1'b1) fd_total++;
        if (m_pss && !ss) begin
          m_len = 0; m_rises = 0; m_bad = 0; m_run = 0; m_word = 16'd0;
          m_fall = cyc; m_pclk = 1'b0;
        end
        if (!ss) begin
          m_len++;
          if (sck != m_pclk) begin
            if (m_pclk && m_run != CD) m_bad++;
            if (!m_pclk && m_rises > 0 && m_run != CD) m_bad++;
            if (sck) begin
              m_rises++;
              m_word = {m_word[14:0], mosi};
            end
            m_run = 1;
          end else begin
            m_run++;
          end
        end else if (!m_pss) begin
          obs_q.push_back('{m_word, m_len, m_rises, m_bad, fdone, m_fall});
        end
        m_pss = ss;
        m_pclk = sck;
      end
    end
  end

  // Driver: present d and hold it until accepted; returns on the falling
  // edge after the accepting edge with sample_valid still high.
  task automatic send1(input logic [11:0] d);
    int k;
    k = 0;
    s_valid = 1'b1;
    s_data = d;
    while (s_ready !== 1'b1 && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (s_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL send_timeout: sample_ready=%b required 1", s_ready);
    end
    @(posedge clk);
    exp_q.push_back({1'b0, 3'b011, d});
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    s_valid = 1'b0; s_data = 12'd0; v2 = 1'b0; d2 = 12'd0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({ss, sck, mosi, busy, fdone, s_ready} !== 6'b100001) begin
      bad++;
      $display("FAIL reset_dut: {ss,clk,mosi,busy,fd,ready}=%b required 100001",
               {ss, sck, mosi, busy, fdone, s_ready});
    end
    total++;
    if ({ss2, sck2, mosi2, b2, fd2, r2} !== 6'b100001) begin
      bad++;
      $display("FAIL reset_dut2: {ss,clk,mosi,busy,fd,ready}=%b required 100001",
               {ss2, sck2, mosi2, b2, fd2, r2});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single;
    frame_t f;
    logic [15:0] e;
    int k;
    s_valid = 1'b1;
    s_data = 12'hABC;
    @(posedge clk);                       // E0: accepted
    exp_q.push_back(16'h3ABC);
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if (ss !== 1'b1 || s_ready !== 1'b0) begin
      bad++;
      $display("FAIL single_after_e0: ss=%b ready=%b required ss=1 ready=0", ss, s_ready);
    end
    @(posedge clk);                       // E1: IDLE loads
    #1;
    total++;
    if ({ss, busy, mosi} !== 3'b010) begin
      bad++;
      $display("FAIL single_after_e1: {ss,busy,mosi}=%b required 010", {ss, busy, mosi});
    end
    k = 0;
    while (obs_q.size() < 1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (obs_q.size() < 1) begin
      bad++;
      $display("FAIL single_timeout: frames=%0d required 1", obs_q.size());
    end else begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (f.word !== e) begin
        bad++;
        $display("FAIL single_word: got %h required %h", f.word, e);
      end
      total++;
      if (f.low_len != SS_LOW || f.rises != 16) begin
        bad++;
        $display("FAIL single_shape: ss_low=%0d rises=%0d required %0d/16",
                 f.low_len, f.rises, SS_LOW);
      end
      total++;
      if (f.bad_half != 0 || f.fd_ok !== 1'b1) begin
        bad++;
        $display("FAIL single_halfper_fd: bad_halves=%0d fd=%b required 0/1",
                 f.bad_half, f.fd_ok);
      end
    end
    repeat (10) @(negedge clk);
    total++;
    if (fd_total != 1) begin
      bad++;
      $display("FAIL single_fd_count: got %0d required 1", fd_total);
    end
  endtask

  task automatic test_back_to_back;
    frame_t f[3];
    logic [15:0] e;
    logic [11:0] vals[3];
    int k;
    vals[0] = 12'h000; vals[1] = 12'hFFF; vals[2] = 12'h800;
    for (int i = 0; i < 3; i++) begin
      send1(vals[i]);
      total++;
      if (s_ready !== 1'b0) begin
        bad++;
        $display("FAIL b2b_ready_low%0d: ready=%b required 0", i, s_ready);
      end
    end
    s_valid = 1'b0;
    k = 0;
    while (obs_q.size() < 3 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (obs_q.size() < 3) begin
      bad++;
      $display("FAIL b2b_timeout: frames=%0d required 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        f[i] = obs_q.pop_front();
        e = exp_q.pop_front();
        total++;
        if (f[i].word !== e) begin
          bad++;
          $display("FAIL b2b_word%0d: got %h required %h", i, f[i].word, e);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (f[i].fall_t - f[i-1].fall_t != PERIOD) begin
          bad++;
          $display("FAIL b2b_spacing%0d: got %0d required %0d", i,
                   f[i].fall_t - f[i-1].fall_t, PERIOD);
        end
      end
    end
    repeat (900) @(negedge clk);
    total++;
    if (obs_q.size() != 0 || fd_total != 4) begin
      bad++;
      $display("FAIL b2b_extra: extra_frames=%0d fd_total=%0d required 0/4",
               obs_q.size(), fd_total);
    end
  endtask

  task automatic test_stall;
    frame_t f;
    logic [15:0] e;
    int k;
    int stalled;
    send1(12'h111);
    send1(12'h222);
    k = 0;
    stalled = 0;
    while (k < 2000) begin
      @(negedge clk);
      s_data = 12'($urandom_range(0, 4095));
      k++;
      if (s_ready === 1'b1) begin
        @(posedge clk);
        exp_q.push_back({4'b0011, s_data});
        break;
      end
      stalled++;
    end
    @(negedge clk);
    s_valid = 1'b0;
    total++;
    if (stalled < 100) begin
      bad++;
      $display("FAIL stall_ready: stalled_cycles=%0d required >=100", stalled);
    end
    k = 0;
    while (obs_q.size() < 3 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (obs_q.size() != 3) begin
      bad++;
      $display("FAIL stall_count: frames=%0d required 3", obs_q.size());
    end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (f.word !== e) begin
        bad++;
        $display("FAIL stall_word: got %h required %h", f.word, e);
      end
    end
    obs_q.delete();
    exp_q.delete();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid;
    frame_t f;
    logic [15:0] e;
    int k;
    send1(12'h5A5);
    s_valid = 1'b0;
    k = 0;
    while (m_rises < 7 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ss, sck, mosi, busy, s_ready} !== 5'b10001 || k >= 2000) begin
      bad++;
      $display("FAIL midreset_pins: {ss,clk,mosi,busy,ready}=%b waited=%0d required 10001",
               {ss, sck, mosi, busy, s_ready}, k);
    end
    void'(exp_q.pop_back());              // aborted frame is never completed
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send1(12'h123);
    s_valid = 1'b0;
    k = 0;
    while (obs_q.size() < 1 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (obs_q.size() != 1) begin
      bad++;
      $display("FAIL midreset_count: frames=%0d required 1", obs_q.size());
    end else begin
      f = obs_q.pop_front();
      e = exp_q.pop_front();
      total++;
      if (f.word !== e || e !== 16'h3123) begin
        bad++;
        $display("FAIL midreset_word: got %h required 3123", f.word);
      end
      total++;
      if (f.low_len != SS_LOW || f.rises != 16 || f.bad_half != 0) begin
        bad++;
        $display("FAIL midreset_shape: ss_low=%0d rises=%0d bad_halves=%0d required %0d/16/0",
                 f.low_len, f.rises, f.bad_half, SS_LOW);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_fast;
    logic [15:0] exp2_q[$];
    logic [15:0] words[2];
    int          lens[2];
    int          rises[2];
    longint      falls[2];
    int          nfr;
    int          fdc;
    logic [15:0] e;
    nfr = 0;
    fdc = 0;
    fork
      begin : drv
        int k;
        logic [11:0] dv[2];
        dv[0] = 12'h5C3; dv[1] = 12'h2A7;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
          v2 = 1'b1;
          d2 = dv[i];
          k = 0;
          while (r2 !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
          end
          @(posedge clk);
          exp2_q.push_back({1'b0, 3'b111, dv[i]});
          @(negedge clk);
        end
        v2 = 1'b0;
      end
      begin : smp
        logic pss, pclk;
        logic [15:0] w;
        int ln, rs;
        longint ft;
        pss = 1'b1; pclk = 1'b0; w = 16'd0; ln = 0; rs = 0; ft = 0;
        for (int c = 0; c < 300 && nfr < 2; c++) begin
          @(negedge clk);
          if (fd2 === 1'b1) fdc++;
          if (pss && !ss2) begin
            w = 16'd0; ln = 0; rs = 0; ft = cyc; pclk = 1'b0;
          end
          if (!ss2) begin
            ln++;
            if (!pclk && sck2) begin
              rs++;
              w = {w[14:0], mosi2};
            end
          end else if (!pss) begin
            words[nfr] = w; lens[nfr] = ln; rises[nfr] = rs; falls[nfr] = ft;
            nfr++;
          end
          pss = ss2;
          pclk = sck2;
        end
      end
    join
    total++;
    if (nfr != 2 || fdc != 2) begin
      bad++;
      $display("FAIL fast_count: frames=%0d fd=%0d required 2/2", nfr, fdc);
    end else begin
      for (int i = 0; i < 2; i++) begin
        e = exp2_q.pop_front();
        total++;
        if (words[i] !== e || lens[i] != 34 || rises[i] != 16) begin
          bad++;
          $display("FAIL fast_frame%0d: word=%h ss_low=%0d rises=%0d required %h/34/16",
                   i, words[i], lens[i], rises[i], e);
        end
      end
      total++;
      if (falls[1] - falls[0] != 36) begin
        bad++;
        $display("FAIL fast_period: got %0d required 36", falls[1] - falls[0]);
      end
    end
  endtask

  task automatic test_idle;
    int viol;
    int fd0;
    s_valid = 1'b0;
    v2 = 1'b0;
    repeat (10) @(negedge clk);
    viol = 0;
    fd0 = fd_total;
    repeat (10000) begin
      @(negedge clk);
      if (ss !== 1'b1 || sck !== 1'b0 || busy !== 1'b0 || fdone !== 1'b0) viol++;
    end
    total++;
    if (viol != 0 || fd_total != fd0 || obs_q.size() != 0) begin
      bad++;
      $display("FAIL idle: violations=%0d new_fd=%0d frames=%0d required 0/0/0",
               viol, fd_total - fd0, obs_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_fast();
    test_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
